// File: rtl/tug_scoreboard.sv
// Tug-of-war match scoreboard: credits one point per round from the edge win
// levels, pulses the playfield round-clear, and drives two 7-segment score digits.
module tug_scoreboard #(
    parameter int unsigned SCORE_MAX    = 7,
    parameter int unsigned CLEAR_CYCLES = 4
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       leftWin,
    input  logic       rightWin,
    output logic       roundReset,
    output logic [3:0] leftScore,
    output logic [3:0] rightScore,
    output logic [6:0] hexLeft,
    output logic [6:0] hexRight,
    output logic       matchOver
);

    localparam int unsigned SCORE_W = 4;
    localparam int unsigned CNT_W   = 8;
    localparam logic [SCORE_W-1:0] SCORE_TOP = SCORE_W'(SCORE_MAX);
    localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(CLEAR_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_PLAY,
        ST_CLEAR,
        ST_DRAIN,
        ST_MATCH_OVER
    } state_e;

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] left_q, left_d;
    logic [SCORE_W-1:0] right_q, right_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               round_reset_q, round_reset_d;
    logic               match_over_q, match_over_d;

    // Active-low 7-segment code, bit0 = segment a .. bit6 = segment g.
    function automatic logic [6:0] seg7(input logic [SCORE_W-1:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= ST_PLAY;
            left_q        <= '0;
            right_q       <= '0;
            cnt_q         <= '0;
            round_reset_q <= 1'b0;
            match_over_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            left_q        <= left_d;
            right_q       <= right_d;
            cnt_q         <= cnt_d;
            round_reset_q <= round_reset_d;
            match_over_q  <= match_over_d;
        end
    end

    // roundReset is registered so it rises together with the credited score.
    always_comb begin
        state_d       = state_q;
        left_d        = left_q;
        right_d       = right_q;
        cnt_d         = cnt_q;
        round_reset_d = 1'b0;
        match_over_d  = match_over_q;

        case (state_q)
            ST_PLAY: begin
                if (leftWin || rightWin) begin
                    state_d       = ST_CLEAR;
                    round_reset_d = 1'b1;
                    cnt_d         = CNT_LOAD;
                    if (leftWin && !rightWin && (left_q < SCORE_TOP)) begin
                        left_d = left_q + 1'b1;
                    end
                    if (rightWin && !leftWin && (right_q < SCORE_TOP)) begin
                        right_d = right_q + 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                if (cnt_q == '0) begin
                    state_d = ST_DRAIN;
                end else begin
                    round_reset_d = 1'b1;
                    cnt_d         = cnt_q - 1'b1;
                end
            end
            // Edge stages must have dropped their sticky wins before a new round.
            ST_DRAIN: begin
                if (!leftWin && !rightWin) begin
                    if ((left_q == SCORE_TOP) || (right_q == SCORE_TOP)) begin
                        state_d      = ST_MATCH_OVER;
                        match_over_d = 1'b1;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
            end
            ST_MATCH_OVER: begin
                match_over_d = 1'b1;
            end
            default: begin
                state_d = ST_PLAY;
            end
        endcase
    end

    assign roundReset = round_reset_q;
    assign leftScore  = left_q;
    assign rightScore = right_q;
    assign matchOver  = match_over_q;
    assign hexLeft    = seg7(left_q);
    assign hexRight   = seg7(right_q);

endmodule
